// File: rtl/cpu_pkg.sv
// cpu_pkg: shared divider controller types and constants
package cpu_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMMIT} div_ctrl_state_t;
    localparam int DIV_ITER = 32;
    localparam int DIV_W = 32;
endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: architectural HI/LO storage with mthi/mtlo vs commit write muxing and rdata mux
module hilo_regs
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             commit,
    input  logic [WIDTH-1:0] c_hi,
    input  logic [WIDTH-1:0] c_lo,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    always_comb begin
        hi_d = commit ? c_hi : (we && wr_hi) ? wdata : hi_q;
        lo_d = commit ? c_lo : (we && wr_lo) ? wdata : lo_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign rdata = rd_hi ? hi_q : rd_lo ? lo_q : '0;
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the iterative signed divider; owns HI/LO and stalls HI/LO access in flight.
// Optional DIV_TIMEOUT_EN aborts a WAIT that reaches TIMEOUT_CYCLES without dv_end.
module div_ctrl
    import cpu_pkg::*;
#(
    parameter int WIDTH = DIV_W,
    parameter int TIMEOUT_CYCLES = DIV_ITER + 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_req,
    input  logic [WIDTH-1:0] div_a,
    input  logic [WIDTH-1:0] div_b,
    output logic             div_ack,
    output logic             busy,
    output logic             div_zero,
    output logic             div_timeout,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic [WIDTH-1:0] rdata,
    output logic             stall,
    output logic             dv_start,
    output logic [WIDTH-1:0] dv_a,
    output logic [WIDTH-1:0] dv_b,
    input  logic             dv_end,
    input  logic [WIDTH-1:0] dv_high,
    input  logic [WIDTH-1:0] dv_low,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    div_ctrl_state_t  state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dv_a_q, dv_a_d, dv_b_q, dv_b_d;
    logic             timeout;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dv_a_d   = dv_a_q;
        dv_b_d   = dv_b_q;
        div_ack  = 1'b0;
        div_zero = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_req) begin
                    div_ack = 1'b1;
                    if (div_b == '0) begin
                        div_zero = 1'b1;
                    end else begin
                        dv_a_d  = div_a;
                        dv_b_d  = div_b;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != CW'(TIMEOUT_CYCLES)) cnt_d = cnt_q + CW'(1);
                if (dv_end) state_d = COMMIT;
`ifdef DIV_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dv_a_q  <= '0;
            dv_b_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dv_a_q  <= dv_a_d;
            dv_b_q  <= dv_b_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign dv_start    = state_q == LAUNCH;
    assign dv_a        = dv_a_q;
    assign dv_b        = dv_b_q;
    assign div_timeout = timeout;
    assign stall       = (busy & (rd_hi | rd_lo | wr_hi | wr_lo)) | (div_req & ~div_ack);

    // mthi/mtlo only land while idle; the requester keeps the strobe up across a stall
    hilo_regs #(.WIDTH(WIDTH)) u_hilo (
        .clk    (clk),
        .reset  (reset),
        .we     (~busy),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .commit (state_q == COMMIT),
        .c_hi   (dv_high),
        .c_lo   (dv_low),
        .rd_hi  (rd_hi),
        .rd_lo  (rd_lo),
        .hi     (hi),
        .lo     (lo),
        .rdata  (rdata)
    );
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Sequencing controller for the iterative 32-cycle signed divider in the multicycle CPU.
- Accepts divide requests from the main control unit and screens for a zero divisor.
- Launches the divider engine and waits for its completion flag.
- Commits quotient/remainder into the architectural HI/LO registers it owns.
- Stalls the control unit on HI/LO access while a divide is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width
TIMEOUT_CYCLES, 40, max WAIT cycles before abort (used only with DIV_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
div_req  input  1  divide request; level, held by requester until div_ack
div_a  input  WIDTH  dividend (signed)
div_b  input  WIDTH  divisor (signed)
div_ack  output  1  one-cycle pulse: request accepted
busy  output  1  high from acceptance through COMMIT
div_zero  output  1  one-cycle pulse: divisor was zero, request dropped
div_timeout  output  1  one-cycle pulse: engine timeout (tied 0 without DIV_TIMEOUT_EN)
wr_hi / wr_lo  input  1  mthi/mtlo write strobes
wdata  input  WIDTH  write data for wr_hi/wr_lo
rd_hi / rd_lo  input  1  mfhi/mflo read strobes
rdata  output  WIDTH  HI if rd_hi, else LO if rd_lo, else 0 (combinational)
stall  output  1  combinational: (busy & (rd_hi|rd_lo|wr_hi|wr_lo)) | (div_req & ~div_ack)
dv_start  output  1  engine start, exactly one cycle
dv_a / dv_b  output  WIDTH  operands registered at acceptance; stable through WAIT
dv_end  input  1  engine done level; cleared by engine on the edge that samples dv_start
dv_high / dv_low  input  WIDTH  engine remainder/quotient
hi / lo  output  WIDTH  architectural HI/LO registers

Behaviour:
- Reset values: all outputs 0, HI=LO=0, state IDLE, counter 0. Reset mid-operation aborts immediately; no commit, dv_start forced 0.
- IDLE:
  - div_req & div_b!=0 -> latch operands, pulse div_ack, go to LAUNCH.
  - div_req & div_b==0 -> pulse div_ack and div_zero in the same cycle, stay IDLE; HI/LO unchanged; engine not started.
- LAUNCH (1 cycle): dv_start=1, busy=1 -> WAIT; counter cleared.
- WAIT: dv_start=0, counter increments each cycle. dv_end=1 -> COMMIT. The counter saturates at TIMEOUT_CYCLES.
- COMMIT (1 cycle): HI<=dv_high, LO<=dv_low, busy=1 -> IDLE; busy drops the following cycle.
- Latency: acceptance edge to HI/LO valid = 1 (LAUNCH) + 32 (engine) + 1 (COMMIT) = 34 cycles. A back-to-back request is accepted on the first IDLE cycle.
- busy=1 in LAUNCH, WAIT and COMMIT. While busy:
  - wr_hi/wr_lo are ignored and stall is asserted; the requester holds the strobe.
  - rd_* assert stall; rdata still shows current HI/LO, but the consumer discards it.
- Simultaneous events in IDLE:
  - wr_hi/wr_lo and div_req in the same cycle: both take effect; the write lands this edge, and the divide later overwrites HI/LO at COMMIT.
  - wr_hi and wr_lo both high: both registers get wdata.
- Signed semantics belong to the engine: quotient truncates toward zero; remainder takes the dividend's sign. The controller does no arithmetic beyond the zero compare.

Optional Feature:
DIV_TIMEOUT_EN
- Defined:
  - If WAIT reaches TIMEOUT_CYCLES without dv_end, go to IDLE and pulse div_timeout for one cycle.
  - HI/LO are unchanged and busy drops.
  - A late dv_end while in IDLE is ignored.
- Undefined: no counter compare, WAIT waits indefinitely, and div_timeout is tied 0.

Decomposition:
- Shared package cpu_pkg:
  - state enum div_ctrl_state_t {IDLE, LAUNCH, WAIT, COMMIT}
  - constant DIV_ITER = 32
  - constant DIV_W = 32
- One natural sub-module, hilo_regs: HI/LO storage, write muxing between mthi/mtlo and commit, plus the rdata mux. The FSM stays in div_ctrl.

Test Plan:
- a=7, b=2 -> div_ack on cycle 0, dv_start on cycle 1; engine stub asserts dv_end 32 cycles later; LO=0x00000003, HI=0x00000001 at cycle 34; busy low at cycle 35.
- a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then rd_lo in IDLE -> rdata=0xFFFFFFFD, stall=0.
- a=5, b=0 -> div_ack and div_zero pulse together; dv_start never asserts; HI/LO keep prior values; busy stays 0.
- rd_hi and wr_lo=0xDEADBEEF asserted during WAIT -> stall=1 every cycle until COMMIT; LO gets 0xDEADBEEF only after busy drops and the strobe is held, so the divide result is overwritten.
- reset low on WAIT cycle 10 -> HI=LO=0, busy=0, dv_start=0; after release a fresh 100/7 gives LO=14, HI=2.
- With DIV_TIMEOUT_EN and the stub never asserting dv_end -> div_timeout pulses when the WAIT counter reaches 40; HI/LO unchanged; the next request is accepted normally.
